// File: rtl/key_debounce_in_if.sv
// Key debounce bus: raw active-low pins in, debounced levels and event pulses out.
// dbg_state carries each key's FSM state (2 bits per key, key i at [2*i +: 2]).
interface key_debounce_in_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0]   key_in_n;
  logic [NUM_KEYS-1:0]   key_level;
  logic [NUM_KEYS-1:0]   key_press;
  logic [NUM_KEYS-1:0]   key_release;
  logic [NUM_KEYS-1:0]   key_long;
  logic [2*NUM_KEYS-1:0] dbg_state;

  modport master (
    output key_in_n,
    input  key_level, key_press, key_release, key_long, dbg_state
  );

  modport slave (
    input  key_in_n,
    output key_level, key_press, key_release, key_long, dbg_state
  );
endinterface

// File: rtl/key_debounce_in.sv
// Per-key 2-flop synchroniser + debounce FSM producing clean levels and press/release pulses.
// Optional long-press pulse is built only when KEY_LONGPRESS_EN is defined.
module key_debounce_in #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  key_debounce_in_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  localparam int MAX_CYC = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  state_t              state_q [NUM_KEYS];
  state_t              state_d [NUM_KEYS];
  logic [CW-1:0]       cnt_q   [NUM_KEYS];
  logic [CW-1:0]       cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_q, press_q, release_q;
  logic [NUM_KEYS-1:0] level_d, press_d, release_d;

  // State register: synchroniser, FSM state/counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= bus.key_in_n;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic; sync2_q is active-low (0 = pressed)
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESS_DB;
            cnt_d[i]   = '0;
          end
        end
        PRESS_DB: begin
          if (sync2_q[i])                  state_d[i] = IDLE;
          else if (cnt_q[i] == DB_LAST)    state_d[i] = PRESSED;
          else if (cnt_q[i] != CNT_MAX)    cnt_d[i]   = cnt_q[i] + CW'(1);
        end
        PRESSED: begin
          if (sync2_q[i]) begin
            state_d[i] = REL_DB;
            cnt_d[i]   = '0;
          end
        end
        REL_DB: begin
          if (!sync2_q[i])                 state_d[i] = PRESSED;
          else if (cnt_q[i] == DB_LAST)    state_d[i] = IDLE;
          else if (cnt_q[i] != CNT_MAX)    cnt_d[i]   = cnt_q[i] + CW'(1);
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Output logic: pulses fire on the accepting transition, level follows the new state
  always_comb begin
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      press_d[i]   = (state_q[i] == PRESS_DB) && !sync2_q[i] && (cnt_q[i] == DB_LAST);
      release_d[i] = (state_q[i] == REL_DB)   &&  sync2_q[i] && (cnt_q[i] == DB_LAST);
      level_d[i]   = (state_d[i] == PRESSED)  || (state_d[i] == REL_DB);
    end
  end

  always_comb begin
    bus.dbg_state = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      bus.dbg_state[2*i +: 2] = state_q[i];
    end
  end

  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;

`ifdef KEY_LONGPRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  logic [CW-1:0]       hold_q [NUM_KEYS];
  logic [CW-1:0]       hold_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] done_q, done_d, long_q, long_d;

  // Hold time only accrues in PRESSED, so a release bounce pauses rather than restarts it
  always_comb begin
    long_d = '0;
    done_d = done_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hold_d[i] = hold_q[i];
      if (state_q[i] == PRESSED) begin
        if (!sync2_q[i] && !done_q[i] && (hold_q[i] == LONG_LAST)) begin
          long_d[i] = 1'b1;
          done_d[i] = 1'b1;
        end else if (hold_q[i] != CNT_MAX) begin
          hold_d[i] = hold_q[i] + CW'(1);
        end
      end
      if (release_d[i]) begin
        hold_d[i] = '0;
        done_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= '0;
      long_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) hold_q[i] <= '0;
    end else begin
      done_q <= done_d;
      long_q <= long_d;
      for (int i = 0; i < NUM_KEYS; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign bus.key_long = long_q;
`else
  assign bus.key_long = '0;
`endif

endmodule
